// File: rtl/hmmm_pkg.sv
// hmmm_pkg
// Shared definitions for the Hmmm register-bus logic: the sequencer state
// encoding, default bus geometry and the requester id constants.
package hmmm_pkg;

  // Sequencer states; TURN is the dead cycle between two bus owners
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TURN = 2'd2
  } seq_state_t;

  localparam int HMMM_NREGS = 16;
  localparam int HMMM_RIDW  = 4;

  // Requester ids, also used as the round-robin priority value
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/hmmm_rr_arb2.sv
// hmmm_rr_arb2
// Two-way round-robin arbiter for the register-bus sequencer.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-low reset (priority returns to A)
//   valid  in   [1:0] request valids, bit 0 = A, bit 1 = B
//   take   in   a grant is being consumed this cycle
//   grant  out  [1:0] one-hot grant, combinational
//   prio   out  current priority holder (0 = A, 1 = B)
module hmmm_rr_arb2
  import hmmm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       take,
  output logic [1:0] grant,
  output logic       prio
);

  logic win_b;
  logic prio_nxt;

  // B wins when it is alone, or when both ask and B holds priority
  assign win_b    = valid[1] && (!valid[0] || (prio == REQ_B));
  assign grant    = {win_b, valid[0] && !win_b};
  assign prio_nxt = win_b ? REQ_A : REQ_B;

  // Priority flop: hands priority to the loser on every consumed grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio <= REQ_A;
    end else if (take) begin
      prio <= prio_nxt;
    end
  end

endmodule

// File: rtl/hmmm_bus_sequencer.sv
// hmmm_bus_sequencer
// Owns every enable of the shared 16-bit register bus. Accepts move requests
// from requester A (control/decode) and B (ALU writeback), arbitrates them
// round-robin and runs each as IDLE -> XFER -> TURN, so exactly one driver is
// ever on the bus and a turnaround cycle separates consecutive owners.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   a_valid/a_ready            requester A handshake (ready is combinational)
//   a_ext, a_src, a_dst        A's source select and register indices
//   b_*                        same for requester B
//   reg_drive [NREGS]          one-hot register output enables (registered)
//   reg_load  [NREGS]          one-hot register latch enables (registered)
//   ext_oe                     external source drives the bus (registered)
//   done, done_id              completion pulse and its requester
//   busy                       sequencer not idle
module hmmm_bus_sequencer
  import hmmm_pkg::*;
#(
  parameter int NREGS = HMMM_NREGS,
  parameter int RIDW  = HMMM_RIDW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_ext,
  input  logic [RIDW-1:0]  a_src,
  input  logic [RIDW-1:0]  a_dst,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_ext,
  input  logic [RIDW-1:0]  b_src,
  input  logic [RIDW-1:0]  b_dst,
  output logic [NREGS-1:0] reg_drive,
  output logic [NREGS-1:0] reg_load,
  output logic             ext_oe,
  output logic             done,
  output logic             done_id,
  output logic             busy
);

  seq_state_t       state, state_nxt;
  logic [1:0]       grant;
  logic             prio;
  logic             hs;
  logic             sel_b;
  logic             sel_ext;
  logic [RIDW-1:0]  sel_src;
  logic [RIDW-1:0]  sel_dst;
  logic             src_ok;
  logic             dst_ok;
  logic             id_q, id_nxt;
  logic [NREGS-1:0] drive_nxt, load_nxt;
  logic             ext_nxt, done_nxt, done_id_nxt;

  hmmm_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({b_valid, a_valid}),
    .take  (hs),
    .grant (grant),
    .prio  (prio)
  );

  // Ready is only offered in IDLE and never while reset is held
  assign a_ready = rst && (state == ST_IDLE) && grant[0];
  assign b_ready = rst && (state == ST_IDLE) && grant[1];
  assign hs      = a_ready || b_ready;

  assign sel_b   = grant[1];
  assign sel_ext = sel_b ? b_ext : a_ext;
  assign sel_src = sel_b ? b_src : a_src;
  assign sel_dst = sel_b ? b_dst : a_dst;

  // Out-of-range indices turn the move into a silent no-op
  assign src_ok  = sel_ext || (int'(sel_src) < NREGS);
  assign dst_ok  = int'(sel_dst) < NREGS;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus next values of the registered outputs. Enables are
  // decoded on the handshake cycle so they appear exactly during XFER.
  always_comb begin
    state_nxt   = state;
    id_nxt      = id_q;
    drive_nxt   = '0;
    load_nxt    = '0;
    ext_nxt     = 1'b0;
    done_nxt    = 1'b0;
    done_id_nxt = REQ_A;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_nxt = ST_XFER;
          id_nxt    = sel_b;
          if (src_ok && dst_ok) begin
            if (sel_ext) begin
              ext_nxt = 1'b1;
            end else begin
              drive_nxt[sel_src] = 1'b1;
            end
            // r0 is hard zero and a register-to-itself move is a no-op
            if ((sel_dst != '0) && (sel_ext || (sel_src != sel_dst))) begin
              load_nxt[sel_dst] = 1'b1;
            end
          end
        end
      end
      ST_XFER: begin
        state_nxt   = ST_TURN;
        done_nxt    = 1'b1;
        done_id_nxt = id_q;
      end
      ST_TURN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output registers; reset clears everything, which also aborts a
  // transfer in flight without a done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q      <= REQ_A;
      reg_drive <= '0;
      reg_load  <= '0;
      ext_oe    <= 1'b0;
      done      <= 1'b0;
      done_id   <= REQ_A;
      busy      <= 1'b0;
    end else begin
      id_q      <= id_nxt;
      reg_drive <= drive_nxt;
      reg_load  <= load_nxt;
      ext_oe    <= ext_nxt;
      done      <= done_nxt;
      done_id   <= done_id_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  a_one_driver: assert property (@(posedge clk)
    ($countones(reg_drive) + int'(ext_oe)) <= 1);
  a_one_loader: assert property (@(posedge clk)
    $countones(reg_load) <= 1);
  a_enables_in_xfer: assert property (@(posedge clk)
    ((|reg_drive) || (|reg_load) || ext_oe) |-> (state == ST_XFER));
  a_done_quiet: assert property (@(posedge clk)
    done |-> !((|reg_drive) || (|reg_load) || ext_oe));
  a_prio_reset: assert property (@(posedge clk)
    !rst |=> (prio == REQ_A));

endmodule

// File: tb/tb_hmmm_bus_sequencer.sv
// tb_hmmm_bus_sequencer
// Scoreboard bench: each accepted request pushes its expected enables into a
// queue, and a monitor pops and compares whenever done pulses. A behavioural
// register bank on the bus lets data movement be checked too.
module tb_hmmm_bus_sequencer;
  import hmmm_pkg::*;

  localparam int NREGS = 16;
  localparam int RIDW  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             a_valid = 1'b0, a_ext = 1'b0;
  logic [RIDW-1:0]  a_src = '0, a_dst = '0;
  logic             b_valid = 1'b0, b_ext = 1'b0;
  logic [RIDW-1:0]  b_src = '0, b_dst = '0;
  logic             a_ready, b_ready;
  logic [NREGS-1:0] reg_drive, reg_load;
  logic             ext_oe, done, done_id, busy;

  typedef struct {
    bit          id;
    logic [15:0] drv;
    logic [15:0] ld;
    bit          ext;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  bit          glog[$];
  int          gcyc[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [15:0] bank [NREGS];
  logic [15:0] ext_data = 16'h0000;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;
  logic [15:0] prv_drv = '0, prv_ld = '0;
  logic        prv_ext = 1'b0;

  hmmm_bus_sequencer #(.NREGS(NREGS), .RIDW(RIDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_ext     (a_ext),
    .a_src     (a_src),
    .a_dst     (a_dst),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_ext     (b_ext),
    .b_src     (b_src),
    .b_dst     (b_dst),
    .reg_drive (reg_drive),
    .reg_load  (reg_load),
    .ext_oe    (ext_oe),
    .done      (done),
    .done_id   (done_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bus_val();
    logic [15:0] v = ext_oe ? ext_data : 16'h0000;
    for (int i = 1; i < NREGS; i++) if (reg_drive[i]) v = v | bank[i];
    return v;
  endfunction

  // Register bank model: r0 is never written and reads as zero
  always @(posedge clk) begin
    if (pl_en) bank[pl_idx] <= pl_val;
    for (int i = 1; i < NREGS; i++) if (reg_load[i]) bank[i] <= bus_val();
  end

  function automatic logic [15:0] model_drv(bit ext, logic [3:0] src);
    return ext ? 16'h0000 : (16'h0001 << src);
  endfunction

  function automatic logic [15:0] model_ld(bit ext, logic [3:0] src, logic [3:0] dst);
    if (dst == 4'd0) return 16'h0000;
    if (!ext && (src == dst)) return 16'h0000;
    return 16'h0001 << dst;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Called on a falling edge; holds the request until ready, logs the grant
  // and pushes the expected response. Returns on the XFER falling edge.
  task automatic applyStimulus(input bit req, input bit ext, input logic [3:0] src,
                               input logic [3:0] dst, input logic [15:0] edrv,
                               input logic [15:0] eld, input bit eext);
    bit   got = 1'b0;
    exp_t e;
    if (req == REQ_A) begin
      a_valid = 1'b1; a_ext = ext; a_src = src; a_dst = dst;
    end else begin
      b_valid = 1'b1; b_ext = ext; b_src = src; b_dst = dst;
    end
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if ((req == REQ_A) ? a_ready : b_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      e.id = req; e.drv = edrv; e.ld = eld; e.ext = eext; e.cyc = cyc;
      sbq.push_back(e);
      glog.push_back(req);
      gcyc.push_back(cyc);
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: requester %0d got no ready, expected one within 20 cycles", req);
    end
    @(negedge clk);
    if (req == REQ_A) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  // Monitor: bus-safety invariants every cycle, scoreboard pop on done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        sbq.delete();
        prv_drv = '0; prv_ld = '0; prv_ext = 1'b0;
      end else begin
        checkOutput("drive_onehot", ($countones(reg_drive) + ext_oe) <= 1, 1);
        checkOutput("load_onehot", $countones(reg_load) <= 1, 1);
        if (done) begin
          checkOutput("turn_enables", {reg_drive, reg_load} | {31'd0, ext_oe}, 0);
          if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected none");
          end else begin
            e = sbq.pop_front();
            checkOutput("done_id", done_id, e.id);
            checkOutput("xfer_drive", prv_drv, e.drv);
            checkOutput("xfer_load", prv_ld, e.ld);
            checkOutput("xfer_ext_oe", prv_ext, e.ext);
            checkOutput("done_latency", cyc - e.cyc, 2);
          end
        end
        prv_drv = reg_drive; prv_ld = reg_load; prv_ext = ext_oe;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs;
    // Reset: ready must stay low even with requests pending
    a_valid = 1'b1; b_valid = 1'b1; a_src = 4'd3; a_dst = 4'd5;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_a_ready", a_ready, 0);
    checkOutput("rst_b_ready", b_ready, 0);
    checkOutput("rst_drive", reg_drive, 0);
    checkOutput("rst_load", reg_load, 0);
    checkOutput("rst_ext_oe", ext_oe, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_done_id", done_id, 0);
    checkOutput("rst_busy", busy, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_drive", reg_drive, 0);
    checkOutput("idle_load", reg_load, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);

    // Contention straight after reset: A first, B three cycles later
    ext_data = 16'h1234;
    glog.delete(); gcyc.delete();
    fork
      applyStimulus(REQ_A, 1'b1, 4'd0, 4'd2, 16'h0000, 16'h0004, 1'b1);
      applyStimulus(REQ_B, 1'b0, 4'd2, 4'd7, 16'h0004, 16'h0080, 1'b0);
    join
    checkOutput("cont_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      checkOutput("cont_first", glog[0], REQ_A);
      checkOutput("cont_second", glog[1], REQ_B);
      checkOutput("cont_spacing", gcyc[1] - gcyc[0], 3);
    end
    repeat (2) @(negedge clk);
    checkOutput("cont_r7", bank[7], 16'h1234);

    // Both held valid: grants alternate A, B, A, B
    glog.delete(); gcyc.delete();
    fork
      for (int i = 0; i < 2; i++)
        applyStimulus(REQ_A, 1'b0, 4'd1, 4'd3, 16'h0002, 16'h0008, 1'b0);
      for (int i = 0; i < 2; i++)
        applyStimulus(REQ_B, 1'b0, 4'd6, 4'd9, 16'h0040, 16'h0200, 1'b0);
    join
    checkOutput("alt_grants", glog.size(), 4);
    if (glog.size() == 4) checkOutput("alt_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);

    // Single move r3 -> r5
    repeat (2) @(negedge clk);
    preload(4'd3, 16'd42);
    gcyc.delete();
    applyStimulus(REQ_A, 1'b0, 4'd3, 4'd5, 16'h0008, 16'h0020, 1'b0);
    hs = (gcyc.size() > 0) ? gcyc[$] : 0;
    checkOutput("move_drive", reg_drive, 16'h0008);
    checkOutput("move_load", reg_load, 16'h0020);
    checkOutput("move_no_done", done, 0);
    @(negedge clk);
    checkOutput("move_done", done, 1);
    checkOutput("move_done_id", done_id, REQ_A);
    checkOutput("move_latency", cyc - hs, 2);
    checkOutput("move_r5", bank[5], 16'd42);

    // r0 destination: no load, still completes
    applyStimulus(REQ_A, 1'b0, 4'd3, 4'd0, 16'h0008, 16'h0000, 1'b0);
    checkOutput("r0_load", reg_load, 0);
    @(negedge clk);
    checkOutput("r0_done", done, 1);

    // src == dst: drive only, register untouched
    preload(4'd4, 16'hBEEF);
    applyStimulus(REQ_B, 1'b0, 4'd4, 4'd4, 16'h0010, 16'h0000, 1'b0);
    checkOutput("self_drive", reg_drive, 16'h0010);
    checkOutput("self_load", reg_load, 0);
    @(negedge clk);
    checkOutput("self_done", done, 1);
    checkOutput("self_done_id", done_id, REQ_B);
    @(negedge clk);
    checkOutput("self_r4", bank[4], 16'hBEEF);

    // Reset during XFER: enables drop, no done, priority back to A
    applyStimulus(REQ_A, 1'b0, 4'd1, 4'd6, 16'h0002, 16'h0040, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_drive", reg_drive, 0);
    checkOutput("abort_load", reg_load, 0);
    checkOutput("abort_ext_oe", ext_oe, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_done_after", done, 0);
    glog.delete();
    fork
      applyStimulus(REQ_A, 1'b0, 4'd2, 4'd8, 16'h0004, 16'h0100, 1'b0);
      applyStimulus(REQ_B, 1'b0, 4'd3, 4'd9, 16'h0008, 16'h0200, 1'b0);
    join
    checkOutput("abort_next_grant", (glog.size() > 0) ? glog[0] : 1'b1, REQ_A);

    // Random traffic from both requesters under the bus-safety monitor
    fork
      for (int i = 0; i < 5000; i++) begin
        bit ext; logic [3:0] s, d;
        if ($urandom_range(3) == 0) @(negedge clk);
        ext = ($urandom_range(3) == 0);
        s = 4'($urandom_range(15)); d = 4'($urandom_range(15));
        applyStimulus(REQ_A, ext, s, d, model_drv(ext, s), model_ld(ext, s, d), ext);
      end
      for (int i = 0; i < 5000; i++) begin
        bit ext; logic [3:0] s, d;
        if ($urandom_range(3) == 0) @(negedge clk);
        ext = ($urandom_range(3) == 0);
        s = 4'($urandom_range(15)); d = 4'($urandom_range(15));
        applyStimulus(REQ_B, ext, s, d, model_drv(ext, s), model_ld(ext, s, d), ext);
      end
    join

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hmmm_bus_sequencer.md
# hmmm_bus_sequencer

Transfer controller for the shared 16-bit register bus of the Hmmm core. It accepts register-to-register and external-to-register move requests from two requesters: A (control/decode unit) and B (ALU writeback). It arbitrates between them round-robin and drives the per-register `read` (drive bus) and `write` (latch bus) enables so that at most one driver is ever on the bus. It sits between the control logic and the bank of `register` instances, and owns every bus enable in the core.

## Interface
Parameters:
- `NREGS`, 16, number of registers on the bus; r0 is hard zero.
- `RIDW`, 4, register index width, equal to clog2(`NREGS`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `a_valid`  in  1  requester A has a transfer.
- `a_ready`  out  1  A's request is accepted this cycle.
- `a_ext`  in  1  1 = source is the external driver (immediate/memory); `a_src` is ignored.
- `a_src`  in  `RIDW`  source register index.
- `a_dst`  in  `RIDW`  destination register index.
- `b_valid`, `b_ready`, `b_ext`, `b_src`, `b_dst`: same as the A ports, for requester B.
- `reg_drive`  out  `NREGS`  one-hot; bit i goes to register i's `read` (output enable onto the bus).
- `reg_load`  out  `NREGS`  one-hot; bit i goes to register i's `write` (latch from the bus).
- `ext_oe`  out  1  external source may drive the bus.
- `done`  out  1  one-cycle pulse: a transfer has completed.
- `done_id`  out  1  requester of the completed transfer (0 = A, 1 = B); valid only with `done`.
- `busy`  out  1  state is not IDLE.

## Operation
- State machine has three states: IDLE, XFER, TURN.
- IDLE:
  - `x_ready` = `x_valid` AND (x is granted), combinational.
  - On handshake, capture src, dst, ext and id, then go to XFER.
  - With no request, stay in IDLE.
- Arbitration:
  - Round-robin pointer `prio` (0 = A, 1 = B).
  - When both requesters are valid, the one named by `prio` wins.
  - When only one is valid, it wins regardless of `prio`.
  - On every grant, `prio` moves to the non-granted requester.
- XFER (exactly 1 cycle):
  - Drive side: assert `reg_drive[src]`, or assert `ext_oe` if ext.
  - Load side: assert `reg_load[dst]`.
  - The destination latches at the end of this cycle. Go to TURN.
- TURN (exactly 1 cycle):
  - All enables are low (bus turnaround).
  - Pulse `done` with `done_id`, then go to IDLE.
- r0 rules:
  - dst = 0: `reg_load` stays all-zero. The transfer still runs XFER and TURN and reports `done`.
  - src = 0 with ext = 0: `reg_drive[0]` is asserted; r0 supplies zero.
- src == dst with ext = 0: `reg_load` is suppressed (no-op), and the transfer still completes.
- Invariants, checked by assertion:
  - popcount(`reg_drive`) + `ext_oe` ≤ 1.
  - popcount(`reg_load`) ≤ 1.
  - Drive and load enables are only ever asserted in XFER.
- Indices ≥ `NREGS` (only possible if `NREGS` < 2^`RIDW`): the transfer is treated as a no-op. It completes with no enables asserted.

## Timing
- Reset values: state = IDLE, `prio` = 0.
- Outputs in reset: `reg_drive` = 0, `reg_load` = 0, `ext_oe` = 0, `done` = 0, `done_id` = 0, `busy` = 0. `x_ready` = 0 while `rst` is low.
- Latency: the handshake in cycle N puts enables in cycle N+1 and `done` in cycle N+2.
  - The next handshake can happen in cycle N+3, so throughput is 1 transfer per 3 cycles.
- `a_ready`/`b_ready` are never asserted outside IDLE.
  - A requester must hold valid and its fields stable until ready is seen.
  - Fields are sampled only on the handshake cycle.
- Reset asserted mid-transfer (in XFER or TURN):
  - All enables are low in the next cycle.
  - No `done` is issued for the aborted transfer.
  - `prio` returns to 0.
- `done` is never asserted in the same cycle as any enable.
- All outputs are registered except `x_ready`.

## Structure
- Shared package `hmmm_pkg`:
  - state encoding: IDLE = 2'd0, XFER = 2'd1, TURN = 2'd2.
  - constants `HMMM_NREGS` = 16 and `HMMM_RIDW` = 4.
  - requester id constants: `REQ_A` = 0, `REQ_B` = 1.
- One sub-module, `hmmm_rr_arb2`: a 2-way round-robin arbiter.
  - Inputs: valids, `prio`.
  - Outputs: one-hot grant and next `prio`.
  - Purely combinational plus the `prio` flop.
- One-hot decode (index → enable vector) stays inline in `hmmm_bus_sequencer`.

## Test plan
- Reset check: hold `rst` low for 2 cycles → all outputs 0, `busy` = 0. Release with no requests → outputs stay 0.
- Single move: preload r3 = 16'd42, then A requests src 3 → dst 5.
  - `a_ready` in cycle N; `reg_drive` = 16'h0008 and `reg_load` = 16'h0020 in N+1.
  - `done` = 1 and `done_id` = 0 in N+2; r5 reads 42.
- Contention: A (ext, dst 2) and B (src 2 → dst 7) both valid from the same cycle after reset.
  - A is granted first, then B, 3 cycles later. r7 reads the external value 16'h1234.
  - Holding both valid continuously → grants alternate A, B, A, B.
- r0 and no-op: dst 0 → `reg_load` = 0, `done` pulses.
  - src = dst = 4 → `reg_drive` = 16'h0010, `reg_load` = 0, r4 unchanged.
- Reset mid-transfer: assert `rst` during XFER → next cycle all enables 0, no `done`. The next request is granted to A.
- Bus-safety monitor over 10k random requests → the one-hot invariant is never violated and no enable is high in TURN.
